// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to CIN x F x F sliding windows.
// Stride 1, no padding; F-1 line buffers feed an F x F shift window.
module conv_window_gen #(
  parameter int WIDTH = 8,
  parameter int F     = 5,
  parameter int CIN   = 3,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CIN*WIDTH-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [CIN*F*F*WIDTH-1:0]     win,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic                         win_last,
  output logic [$clog2(IMG_H)-1:0]     win_row,
  output logic [$clog2(IMG_W)-1:0]     win_col
);

  localparam int PW = CIN*WIDTH;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [PW-1:0]    lb [F-1][IMG_W];
  logic [WIDTH-1:0] wr [CIN][F][F];
  logic [PW-1:0]    col_new [F];
  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic             acc;
  logic             col_end;
  logic             row_end;
  logic             hit;

  assign in_ready = !win_valid || win_ready;
  assign acc      = in_valid && in_ready;
  assign col_end  = col_cnt == CW'(IMG_W-1);
  assign row_end  = row_cnt == RW'(IMG_H-1);
  assign hit      = (row_cnt >= RW'(F-1)) &&
                    (col_cnt >= CW'(F-1));

  // column entering the window, top row first, newest pixel last
  always_comb begin
    for (int i = 0; i < F-1; i++) begin
      col_new[i] = lb[F-2-i][col_cnt];
    end
    col_new[F-1] = in_data;
  end

  // line buffers cascade one row down per accept; contents not reset
  always_ff @(posedge clk) begin
    if (acc) begin
      lb[0][col_cnt] <= in_data;
      for (int k = 1; k < F-1; k++) begin
        lb[k][col_cnt] <= lb[k-1][col_cnt];
      end
    end
  end

  // raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (acc) begin
      if (col_end) begin
        col_cnt <= '0;
        row_cnt <= row_end ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // window shifts left and loads the new column on each accept
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CIN; c++) begin
        for (int i = 0; i < F; i++) begin
          for (int j = 0; j < F; j++) begin
            wr[c][i][j] <= '0;
          end
        end
      end
    end else if (acc) begin
      for (int c = 0; c < CIN; c++) begin
        for (int i = 0; i < F; i++) begin
          for (int j = 0; j < F-1; j++) begin
            wr[c][i][j] <= wr[c][i][j+1];
          end
          wr[c][i][F-1] <= col_new[i][c*WIDTH +: WIDTH];
        end
      end
    end
  end

  // flatten window register to element n = c*F*F + i*F + j
  always_comb begin
    win = '0;
    for (int c = 0; c < CIN; c++) begin
      for (int i = 0; i < F; i++) begin
        for (int j = 0; j < F; j++) begin
          win[(c*F*F + i*F + j)*WIDTH +: WIDTH] = wr[c][i][j];
        end
      end
    end
  end

  // window valid/position tracking with hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (acc) begin
      win_valid <= hit;
      win_last  <= hit && row_end && col_end;
      if (hit) begin
        win_row <= row_cnt;
        win_col <= col_cnt;
      end
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized self-checking bench for conv_window_gen.
// Windows are compared against a model built straight from pixel coordinates.
module tb_conv_window_gen;

  localparam int W   = 8;
  localparam int F   = 3;
  localparam int CIN = 2;
  localparam int IW  = 6;
  localparam int IH  = 5;
  localparam int NW  = CIN*F*F*W;
  localparam int NWIN = (IH-F+1)*(IW-F+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CIN*W-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NW-1:0]     win;
  logic              win_valid;
  logic              win_ready = 1'b1;
  logic              win_last;
  logic [2:0]        win_row;
  logic [2:0]        win_col;

  typedef struct {
    logic [NW-1:0] w;
    int            r;
    int            c;
    logic          l;
  } rec_t;

  rec_t capq[$];
  int   acc_cnt = 0;
  int   rdy_mode = 0;
  int   total = 0;
  int   bad = 0;

  conv_window_gen #(
    .WIDTH(W), .F(F), .CIN(CIN), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .win(win),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_last(win_last),
    .win_row(win_row),
    .win_col(win_col)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // record handshakes seen ahead of the coming rising edge
  always @(negedge clk) begin
    rec_t t;
    if (!rst && win_valid && win_ready) begin
      t.w = win;
      t.r = int'(win_row);
      t.c = int'(win_col);
      t.l = win_last;
      capq.push_back(t);
    end
    if (!rst && in_valid && in_ready) acc_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) win_ready = 1'b1;
    else if (rdy_mode == 1) win_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [7:0] pix(int r, int k, int c, int off);
    return 8'((r*16 + k + 128*c + off) & 255);
  endfunction

  function automatic logic [NW-1:0] model_win(int r, int k, int off);
    logic [NW-1:0] v = '0;
    for (int c = 0; c < CIN; c++)
      for (int i = 0; i < F; i++)
        for (int j = 0; j < F; j++)
          v[(c*F*F + i*F + j)*W +: W] = pix(r-F+1+i, k-F+1+j, c, off);
    return v;
  endfunction

  task automatic send_pixel(input int r, input int k, input int off,
                            input int gapmax);
    int t;
    repeat ($urandom_range(0, gapmax)) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < CIN; c++) in_data[c*W +: W] = pix(r, k, c, off);
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout pixel (%0d,%0d) in_ready=%0b want 1",
               r, k, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int off, input int gapmax);
    for (int r = 0; r < IH; r++)
      for (int k = 0; k < IW; k++)
        send_pixel(r, k, off, gapmax);
  endtask

  task automatic drain();
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (win_valid !== 1'b0 || win_last !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_flags got v=%0b l=%0b rdy=%0b want 0 0 1",
               win_valid, win_last, in_ready);
    end
    total++;
    if (win !== '0 || win_row !== 3'd0 || win_col !== 3'd0) begin
      bad++;
      $display("FAIL reset_regs got row=%0d col=%0d win=%h want 0 0 0",
               win_row, win_col, win);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    capq.delete();
    rdy_mode = 0;
    for (int r = 0; r < IH; r++) begin
      for (int k = 0; k < IW; k++) begin
        send_pixel(r, k, 0, 0);
        if (r < F-1 || k < F-1) begin
          total++;
          if (win_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_window after (%0d,%0d) got %0b want 0",
                     r, k, win_valid);
          end
        end
        if (r == 2 && k == 2) begin
          total++;
          if (win_valid !== 1'b1 || win_row !== 3'd2 || win_col !== 3'd2) begin
            bad++;
            $display("FAIL first_window got v=%0b (%0d,%0d) want 1 (2,2)",
                     win_valid, win_row, win_col);
          end
          total++;
          if (win[0 +: 8] !== 8'h00 || win[64 +: 8] !== 8'h22 ||
              win[72 +: 8] !== 8'h80 || win[136 +: 8] !== 8'hA2) begin
            bad++;
            $display("FAIL first_elems got %h %h %h %h want 00 22 80 a2",
                     win[0 +: 8], win[64 +: 8], win[72 +: 8], win[136 +: 8]);
          end
        end
      end
    end
    drain();
    total++;
    if (capq.size() != NWIN) begin
      bad++;
      $display("FAIL full_count got %0d want %0d", capq.size(), NWIN);
    end
    for (int n = 0; n < capq.size() && n < NWIN; n++) begin
      total++;
      if (capq[n].w !== model_win(2 + n/4, 2 + n%4, 0) ||
          capq[n].r != 2 + n/4 || capq[n].c != 2 + n%4 ||
          capq[n].l !== (n == NWIN-1)) begin
        bad++;
        $display("FAIL full_win%0d got (%0d,%0d) l=%0b want (%0d,%0d) l=%0b",
                 n, capq[n].r, capq[n].c, capq[n].l,
                 2 + n/4, 2 + n%4, n == NWIN-1);
      end
    end
    if (capq.size() == NWIN) begin
      total++;
      if (capq[NWIN-1].w[64 +: 8] !== 8'h45) begin
        bad++;
        $display("FAIL last_elem got %h want 45", capq[NWIN-1].w[64 +: 8]);
      end
    end
  endtask

  task automatic test_backpressure();
    int a0;
    capq.delete();
    rdy_mode = 2;
    win_ready = 1'b1;
    for (int p = 0; p <= 2*IW + 2; p++) send_pixel(p/IW, p%IW, 0, 0);
    win_ready = 1'b0;
    for (int c = 0; c < CIN; c++) in_data[c*W +: W] = pix(2, 3, c, 0);
    in_valid = 1'b1;
    a0 = acc_cnt;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (win_valid !== 1'b1 || win !== model_win(2, 2, 0) ||
          win_row !== 3'd2 || win_col !== 3'd2 || win_last !== 1'b0) begin
        bad++;
        $display("FAIL hold_win got v=%0b (%0d,%0d) want 1 (2,2)",
                 win_valid, win_row, win_col);
      end
      total++;
      if (in_ready !== 1'b0 || acc_cnt != a0) begin
        bad++;
        $display("FAIL hold_ready got rdy=%0b acc=%0d want 0 %0d",
                 in_ready, acc_cnt, a0);
      end
      @(posedge clk); #1;
    end
    win_ready = 1'b1;
    for (int p = 2*IW + 3; p < IW*IH; p++) send_pixel(p/IW, p%IW, 0, 0);
    drain();
    total++;
    if (capq.size() != NWIN) begin
      bad++;
      $display("FAIL bp_count got %0d want %0d", capq.size(), NWIN);
    end
    if (capq.size() > 1) begin
      total++;
      if (capq[1].r != 2 || capq[1].c != 3 || capq[1].w[0 +: 8] !== 8'h01) begin
        bad++;
        $display("FAIL bp_next got (%0d,%0d) x0=%h want (2,3) 01",
                 capq[1].r, capq[1].c, capq[1].w[0 +: 8]);
      end
    end
  endtask

  task automatic test_random();
    capq.delete();
    rdy_mode = 1;
    send_frame(0, 2);
    drain();
    total++;
    if (capq.size() != NWIN) begin
      bad++;
      $display("FAIL rand_count got %0d want %0d", capq.size(), NWIN);
    end
    for (int n = 0; n < capq.size() && n < NWIN; n++) begin
      total++;
      if (capq[n].w !== model_win(2 + n/4, 2 + n%4, 0) ||
          capq[n].r != 2 + n/4 || capq[n].c != 2 + n%4 ||
          capq[n].l !== (n == NWIN-1)) begin
        bad++;
        $display("FAIL rand_win%0d got (%0d,%0d) l=%0b want (%0d,%0d)",
                 n, capq[n].r, capq[n].c, capq[n].l, 2 + n/4, 2 + n%4);
      end
    end
  endtask

  task automatic test_back_to_back();
    capq.delete();
    rdy_mode = 0;
    send_frame(0, 0);
    send_frame(8, 0);
    drain();
    total++;
    if (capq.size() != 2*NWIN) begin
      bad++;
      $display("FAIL b2b_count got %0d want %0d", capq.size(), 2*NWIN);
    end
    for (int n = 0; n < capq.size() && n < 2*NWIN; n++) begin
      int m;
      m = n % NWIN;
      total++;
      if (capq[n].w !== model_win(2 + m/4, 2 + m%4, n < NWIN ? 0 : 8) ||
          capq[n].r != 2 + m/4 || capq[n].c != 2 + m%4 ||
          capq[n].l !== (m == NWIN-1)) begin
        bad++;
        $display("FAIL b2b_win%0d got (%0d,%0d) l=%0b want (%0d,%0d)",
                 n, capq[n].r, capq[n].c, capq[n].l, 2 + m/4, 2 + m%4);
      end
    end
    if (capq.size() > NWIN) begin
      total++;
      if (capq[NWIN].w[0 +: 8] !== 8'h08) begin
        bad++;
        $display("FAIL b2b_first got %h want 08", capq[NWIN].w[0 +: 8]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rdy_mode = 0;
    for (int p = 0; p < 20; p++) send_pixel(p/IW, p%IW, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (win_valid !== 1'b0 || in_ready !== 1'b1 || win_last !== 1'b0) begin
      bad++;
      $display("FAIL midrst_flags got v=%0b rdy=%0b l=%0b want 0 1 0",
               win_valid, in_ready, win_last);
    end
    total++;
    if (win !== '0 || win_row !== 3'd0 || win_col !== 3'd0) begin
      bad++;
      $display("FAIL midrst_regs got (%0d,%0d) win=%h want (0,0) 0",
               win_row, win_col, win);
    end
    capq.delete();
    send_frame(0, 1);
    drain();
    total++;
    if (capq.size() != NWIN) begin
      bad++;
      $display("FAIL midrst_count got %0d want %0d", capq.size(), NWIN);
    end
    for (int n = 0; n < capq.size() && n < NWIN; n++) begin
      total++;
      if (capq[n].w !== model_win(2 + n/4, 2 + n%4, 0) ||
          capq[n].r != 2 + n/4 || capq[n].c != 2 + n%4) begin
        bad++;
        $display("FAIL midrst_win%0d got (%0d,%0d) want (%0d,%0d)",
                 n, capq[n].r, capq[n].c, 2 + n/4, 2 + n%4);
      end
    end
  endtask

  task automatic test_row_boundary();
    logic [NW-1:0] w;
    logic [7:0]    v;
    int            stale;
    if (capq.size() > 4) begin
      w = capq[4].w;
      total++;
      if (capq[4].r != 3 || capq[4].c != 2 ||
          w[0 +: 8] !== 8'h10 || w[16 +: 8] !== 8'h12) begin
        bad++;
        $display("FAIL rowb_elems got (%0d,%0d) %h %h want (3,2) 10 12",
                 capq[4].r, capq[4].c, w[0 +: 8], w[16 +: 8]);
      end
      stale = 0;
      for (int n = 0; n < CIN*F*F; n++) begin
        v = w[n*W +: W];
        if (v[6:0] == 7'h23 || v[6:0] == 7'h24 || v[6:0] == 7'h25) stale++;
      end
      total++;
      if (stale != 0) begin
        bad++;
        $display("FAIL rowb_stale got %0d stale elems want 0", stale);
      end
    end else begin
      total++; bad++;
      $display("FAIL rowb_missing got %0d windows want >4", capq.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_row_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
